// File: rtl/sipo_deserializer_if.sv
// Parallel-side bundle of the SIPO deserializer: serial input strobes in,
// assembled word plus status out. The master drives the serial stream and
// pout_ready. The slave is the deserializer itself.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             frame_start;
    logic             pout_ready;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output sin, sin_valid, frame_start, pout_ready,
        input  pout, pout_valid, busy, frame_err, overrun
    );

    modport slave (
        input  sin, sin_valid, frame_start, pout_ready,
        output pout, pout_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer. It collects framed serial bits into
// WIDTH-bit words and offers each completed word on a single-entry
// valid/ready holding register. A word that completes while the holding
// register is full and not being drained is dropped and flagged as overrun.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input logic                clk,
    input logic                rst,
    sipo_deserializer_if.slave bus
);
    localparam int unsigned    CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_pout;
    logic             r_pout_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_shifted;
    logic             w_take;

    // Build the first-bit word and the next shift value for the configured bit order.
    always_comb begin
        w_first   = '0;
        w_shifted = '0;
        if (MSB_FIRST != 0) begin
            w_first[0] = bus.sin;
            w_shifted  = {r_shift[WIDTH-2:0], bus.sin};
        end else begin
            w_first[WIDTH-1] = bus.sin;
            w_shifted        = {bus.sin, r_shift[WIDTH-1:1]};
        end
    end

    // The holding register can accept a new word when it is empty or being drained this cycle.
    assign w_take = !r_pout_valid || bus.pout_ready;

    // Assembly FSM, holding register and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_pout       <= '0;
            r_pout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_pout_valid && bus.pout_ready) begin
                r_pout_valid <= 1'b0;
            end
            if (bus.sin_valid) begin
                case (r_state)
                    IDLE: begin
                        if (bus.frame_start) begin
                            r_shift <= w_first;
                            r_cnt   <= CW'(1);
                            r_state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (bus.frame_start) begin
                            // Restart wins over completion, even on the last bit.
                            r_shift     <= w_first;
                            r_cnt       <= CW'(1);
                            r_frame_err <= 1'b1;
                        end else if (r_cnt == LAST) begin
                            r_shift <= w_shifted;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                            if (w_take) begin
                                r_pout       <= w_shifted;
                                r_pout_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_shift <= w_shifted;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pout       = r_pout;
    assign bus.pout_valid = r_pout_valid;
    assign bus.busy       = (r_state == SHIFT);
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer. Two instances (MSB-first and
// LSB-first) see the same stimulus. The LSB-first word is the bit reverse
// of the MSB-first word.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(4)) bus1 ();
    sipo_deserializer_if #(.WIDTH(4)) bus0 ();

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    typedef struct {
        logic       rst, sv, fs, sin, rdy;
        logic [3:0] pout;
        logic       pv, busy, fe, ov;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic r, sv, fs, s, rdy,
                                input logic [3:0] p, input logic pv, b, fe, ov);
        vec_t v;
        v.rst = r; v.sv = sv; v.fs = fs; v.sin = s; v.rdy = rdy;
        v.pout = p; v.pv = pv; v.busy = b; v.fe = fe; v.ov = ov;
        return v;
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, sv, fs, s, rdy);
        rst = r;
        bus1.sin_valid = sv; bus1.frame_start = fs; bus1.sin = s; bus1.pout_ready = rdy;
        bus0.sin_valid = sv; bus0.frame_start = fs; bus0.sin = s; bus0.pout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] p,
                             input logic pv, b, fe, ov);
        chk({tag, " pout_msb"}, 32'(bus1.pout), 32'(p));
        chk({tag, " pout_lsb"}, 32'(bus0.pout), 32'(rev4(p)));
        chk({tag, " pv"},   32'(bus1.pout_valid), 32'(pv));
        chk({tag, " pv0"},  32'(bus0.pout_valid), 32'(pv));
        chk({tag, " busy"}, 32'(bus1.busy), 32'(b));
        chk({tag, " busy0"}, 32'(bus0.busy), 32'(b));
        chk({tag, " ferr"}, 32'(bus1.frame_err), 32'(fe));
        chk({tag, " ovr"},  32'(bus1.overrun), 32'(ov));
    endtask

    // Sends one framed word MSB first; intermediate bits must show busy and no frame error.
    task automatic send(input string tag, input logic [3:0] w, input logic rdy_mid, input logic rdy_last);
        logic [3:0] wv;
        wv = w;
        for (int i = 3; i >= 1; i--) begin
            apply(1'b0, 1'b1, (i == 3), wv[i], rdy_mid);
            chk($sformatf("%s bit%0d busy", tag, 3 - i), 32'(bus1.busy), 32'd1);
            chk($sformatf("%s bit%0d ferr", tag, 3 - i), 32'(bus1.frame_err), 32'd0);
        end
        apply(1'b0, 1'b1, 1'b0, wv[0], rdy_last);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // columns: rst sv fs sin rdy | pout pv busy ferr ovr
        vecs.push_back(mk(1,0,0,0,1, 4'h0,0,0,0,0)); // reset
        vecs.push_back(mk(0,1,1,1,1, 4'h0,0,1,0,0)); // word 1011
        vecs.push_back(mk(0,1,0,0,1, 4'h0,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'h0,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'hB,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 4'hB,0,0,0,0)); // handshake
        vecs.push_back(mk(0,1,0,1,1, 4'hB,0,0,0,0)); // stray bits in IDLE
        vecs.push_back(mk(0,1,0,0,1, 4'hB,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,1, 4'hB,0,1,0,0)); // word 0110 with gaps
        vecs.push_back(mk(0,0,1,1,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,0,1,1,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,0,1,0,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,0,1,0,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,0,1,1,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,0,1,1,1, 4'hB,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,1, 4'h6,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 4'h6,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1, 4'h6,0,1,0,0)); // abort after 1,1
        vecs.push_back(mk(0,1,0,1,1, 4'h6,0,1,0,0));
        vecs.push_back(mk(0,1,1,0,1, 4'h6,0,1,1,0));
        vecs.push_back(mk(0,1,0,0,1, 4'h6,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,1, 4'h6,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'h1,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 4'h1,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1, 4'h1,0,1,0,0)); // frame_start on the last bit
        vecs.push_back(mk(0,1,0,0,1, 4'h1,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'h1,0,1,0,0));
        vecs.push_back(mk(0,1,1,1,1, 4'h1,0,1,1,0));
        vecs.push_back(mk(0,1,0,0,1, 4'h1,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'h1,0,1,0,0));
        vecs.push_back(mk(0,1,0,1,1, 4'hB,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 4'hB,0,0,0,0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].sv, vecs[i].fs, vecs[i].sin, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].pout, vecs[i].pv,
                      vecs[i].busy, vecs[i].fe, vecs[i].ov);
        end

        // Back-pressure: A held, B dropped with overrun, C loaded without a bubble.
        send("A", 4'hA, 1'b0, 1'b0);
        check_all("A done", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        send("B", 4'h5, 1'b0, 1'b0);
        check_all("B dropped", 4'hA, 1'b1, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("ovr clear", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        send("C", 4'h3, 1'b0, 1'b1);
        check_all("C no bubble", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all("C drained", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame, then a clean word.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("pre-reset", 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_all("mid reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("W9", 4'h9, 1'b1, 1'b1);
        check_all("W9 done", 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
